// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store initiator for a word-organised data memory.
// Accepts one request at a time, performs lane extraction with sign/zero
// extension for loads, read-modify-write for SB/SH, and flags misaligned or
// out-of-range accesses without touching the memory.
module dmem_access_unit #(
    parameter int unsigned ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_cs,
    output logic              dmem_r,
    output logic              dmem_w,
    output logic [31:0]       dmem_wr_data,
    input  logic [31:0]       dmem_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         base_q, base_d;
    logic                err_q, err_d;
    logic [31:0]         load_data_q, load_data_d;

    logic [31:0]         off;
    logic                out_of_range;
    logic                misaligned;
    logic [31:0]         merged;

    // Extend the addressed lane of a read word according to the load type.
    function automatic logic [31:0] extend_load(input op_e op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res;
        half_v = lane[1] ? word[31:16] : word[15:0];
        byte_v = word[{lane, 3'b000} +: 8];
        case (op)
            OP_LH:   res = {{16{half_v[15]}}, half_v};
            OP_LHU:  res = {16'h0000, half_v};
            OP_LB:   res = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  res = {24'h00_0000, byte_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Request decode: offset, range and alignment checks.
    always_comb begin
        off          = req_addr - BASE_ADDR;
        out_of_range = |off[31:ADDR_W+2];
        misaligned   = 1'b0;
        case (op_e'(req_op))
            OP_LW, OP_SW:         misaligned = |req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    // Store data merge: SW passes through, SH/SB replace one lane of the read word.
    always_comb begin
        merged = base_q;
        case (op_q)
            OP_SH:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: merged = wdata_q;
        endcase
    end

    // Next-state and latched-field logic; err/load_data update only on entry to DONE.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        base_d      = base_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    addr_d  = off[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    if (out_of_range || misaligned) begin
                        err_d       = 1'b1;
                        load_data_d = '0;
                        state_d     = S_DONE;
                    end else if (op_e'(req_op) == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (op_q == OP_SH || op_q == OP_SB) begin
                    base_d  = dmem_rd_data;
                    state_d = S_WR;
                end else begin
                    load_data_d = extend_load(op_q, addr_q[1:0], dmem_rd_data);
                    err_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_WR: begin
                load_data_d = '0;
                err_d       = 1'b0;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LW;
            addr_q      <= '0;
            wdata_q     <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            base_q      <= base_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    // Memory-side decode; all strobes forced low while rst is high so no write commits.
    always_comb begin
        dmem_cs      = 1'b0;
        dmem_r       = 1'b0;
        dmem_w       = 1'b0;
        dmem_addr    = '0;
        dmem_wr_data = '0;
        if (!rst) begin
            case (state_q)
                S_RD: begin
                    dmem_cs   = 1'b1;
                    dmem_r    = 1'b1;
                    dmem_addr = addr_q[ADDR_W+1:2];
                end
                S_WR: begin
                    dmem_cs      = 1'b1;
                    dmem_w       = 1'b1;
                    dmem_addr    = addr_q[ADDR_W+1:2];
                    dmem_wr_data = merged;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized
// traffic compared against a word-array reference model of the memory.
module tb_dmem_access_unit;

    localparam int unsigned ADDR_W = 11;
    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam int unsigned NWORDS = 1 << ADDR_W;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [2:0]        req_op = '0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              busy, done, err;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_cs, dmem_r, dmem_w;
    logic [31:0]       dmem_wr_data;
    logic [31:0]       dmem_rd_data;

    // Memory the DUT talks to, and the bench's own expectation of its contents.
    bit [31:0] mem     [NWORDS];
    bit [31:0] ref_mem [NWORDS];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    dmem_access_unit #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .err(err), .load_data(load_data), .dmem_addr(dmem_addr),
        .dmem_cs(dmem_cs), .dmem_r(dmem_r), .dmem_w(dmem_w),
        .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data)
    );

    always #5 clk = ~clk;

    assign dmem_rd_data = mem[dmem_addr];
    always @(posedge clk) begin
        if (dmem_cs && dmem_w) mem[dmem_addr] <= dmem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Run one request to completion and compare against the reference model.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off, word, lane_v, exp_data, exp_wr, mask;
        bit          exp_err, is_load;
        int unsigned exp_lat, exp_rd, exp_wrc, lat, rd_cnt, wr_cnt, sh;
        off     = addr - BASE;
        is_load = (op <= LBU);
        exp_err = (off >= 4 * NWORDS) ||
                  ((op == LW || op == SW) && addr[1:0] != 2'b00) ||
                  ((op == LH || op == LHU || op == SH) && addr[0]);
        word     = exp_err ? 32'h0 : ref_mem[off / 4];
        exp_data = 32'h0;
        exp_wr   = 32'h0;
        if (!exp_err && is_load) begin
            if (op == LW) exp_data = word;
            else if (op == LH || op == LHU) begin
                lane_v   = (word >> (16 * ((off / 2) % 2))) & 32'hFFFF;
                exp_data = (op == LH && lane_v >= 32'h8000) ? (lane_v | 32'hFFFF_0000) : lane_v;
            end else begin
                lane_v   = (word >> (8 * (off % 4))) & 32'hFF;
                exp_data = (op == LB && lane_v >= 32'h80) ? (lane_v | 32'hFFFF_FF00) : lane_v;
            end
        end
        if (!exp_err && !is_load) begin
            if (op == SW) exp_wr = wd;
            else begin
                sh     = (op == SH) ? 16 * ((off / 2) % 2) : 8 * (off % 4);
                mask   = ((op == SH) ? 32'hFFFF : 32'hFF) << sh;
                exp_wr = (word & ~mask) | ((wd << sh) & mask);
            end
        end
        exp_lat = exp_err ? 1 : (op == SH || op == SB) ? 3 : 2;
        exp_rd  = (!exp_err && op != SW) ? 1 : 0;
        exp_wrc = (!exp_err && !is_load) ? 1 : 0;

        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        lat = 0; rd_cnt = 0; wr_cnt = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (dmem_cs && dmem_r) rd_cnt++;
            if (dmem_cs && dmem_w) begin
                wr_cnt++;
                check("wr_addr", {21'h0, dmem_addr}, off / 4);
                check("wr_data", dmem_wr_data, exp_wr);
            end
            if (done) lat = n;
            else check("busy", {31'h0, busy}, 1);
        end
        check("latency", lat, exp_lat);
        check("err", {31'h0, err}, {31'h0, exp_err});
        check("load_data", load_data, exp_data);
        check("rd_cycles", rd_cnt, exp_rd);
        check("wr_cycles", wr_cnt, exp_wrc);
        @(posedge clk); #1;
        check("done_pulse", {30'h0, done, busy}, 0);
        if (!exp_err && !is_load) ref_mem[off / 4] = exp_wr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned dones;
        bit          wseen;
        logic [2:0]  rop;
        logic [31:0] raddr;

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        // Idle after reset: everything low.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_ctl", {26'h0, busy, done, err, dmem_cs, dmem_r, dmem_w}, 0);
            check("idle_data", load_data | dmem_wr_data | {21'h0, dmem_addr}, 0);
        end

        // SW then LW.
        do_req(SW, 32'h1001_0008, 32'hDEAD_BEEF);
        do_req(LW, 32'h1001_0008, 32'h0);
        check("lw_deadbeef", load_data, 32'hDEAD_BEEF);

        // Lane extraction on 0x8081_7F01.
        do_req(SW, 32'h1001_0004, 32'h8081_7F01);
        do_req(LB, 32'h1001_0005, 32'h0);  check("lb5", load_data, 32'h0000_007F);
        do_req(LB, 32'h1001_0007, 32'h0);  check("lb7", load_data, 32'hFFFF_FF80);
        do_req(LBU, 32'h1001_0007, 32'h0); check("lbu7", load_data, 32'h0000_0080);
        do_req(LH, 32'h1001_0006, 32'h0);  check("lh6", load_data, 32'hFFFF_8081);
        do_req(LHU, 32'h1001_0006, 32'h0); check("lhu6", load_data, 32'h0000_8081);

        // SB read-modify-write.
        do_req(SW, 32'h1001_0004, 32'h1122_3344);
        do_req(SB, 32'h1001_0005, 32'h0000_00AA);
        do_req(LW, 32'h1001_0004, 32'h0);  check("sb_merge", load_data, 32'h1122_AA44);

        // Error requests.
        do_req(LW, 32'h1001_0002, 32'h0);
        do_req(SH, 32'h1001_0001, 32'h1234);
        do_req(LB, 32'h1001_2000, 32'h0);
        do_req(LW, 32'h1000_FFFC, 32'h0);
        do_req(SW, 32'h1001_1FFC, 32'hCAFE_F00D);
        do_req(LW, 32'h1001_1FFC, 32'h0);  check("top_word", load_data, 32'hCAFE_F00D);

        // Reset during the RD cycle of an SB abandons the write.
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h1001_0010; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_rd", {30'h0, dmem_cs, dmem_r}, 3);
        rst = 1'b1; #1;
        check("rst_gate", {29'h0, dmem_cs, dmem_r, dmem_w}, 0);
        wseen = 1'b0; dones = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'h0, busy}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (dmem_w) wseen = 1'b1;
            if (done) dones++;
        end
        check("abort_no_w", {31'h0, wseen}, 0);
        check("abort_no_done", dones, 0);
        do_req(LW, 32'h1001_0010, 32'h0);

        // A request pulse while busy is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h1001_0008; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        dones = done ? 1 : 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = SW; req_addr = 32'h1001_0008; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (done) begin
            dones++;
            check("busy_lw", load_data, ref_mem[2]);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("one_done", dones, 1);
        do_req(LW, 32'h1001_0008, 32'h0);

        // Randomized traffic over a small window plus out-of-range addresses.
        for (int t = 0; t < 200; t++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       raddr = BASE + 32'h2000 + $urandom_range(0, 255);
                1:       raddr = BASE - 32'($urandom_range(1, 64));
                default: raddr = BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            endcase
            do_req(rop, raddr, $urandom);
        end

        // Final sweep: memory seen by the DUT matches the model.
        for (int i = 0; i < 64; i++) check("mem_sweep", mem[i], ref_mem[i]);
        check("mem_top", mem[NWORDS-1], ref_mem[NWORDS-1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
